// File: rtl/gpio_seq_ctrl.sv
// Sequence controller for the GPIO bank: walks a one-hot active pin across a
// shadowed pin window (wrap or ping-pong), holding each pin a prescaled number of ms.
module gpio_seq_ctrl #(
  parameter int unsigned NUM_PINS    = 34,
  parameter int unsigned CLKS_PER_MS = 10000
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic                start,
  input  logic                stop,
  input  logic [13:0]         prescaler,
  input  logic [5:0]          first_pin,
  input  logic [5:0]          last_pin,
  input  logic [7:0]          repeat_cnt,
  input  logic                pingpong,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oeb,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [5:0]          cur_pin,
  output logic [7:0]          loop_count
);

  localparam int unsigned PIN_W = 6;
  localparam int unsigned PRE_W = 14;
  localparam int unsigned RPT_W = 8;
  localparam int unsigned DIV_W = 28;
  localparam logic [PIN_W:0] PIN_LIM = (PIN_W+1)'(NUM_PINS);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t             r_state, w_nxt_state;
  logic [PIN_W-1:0]   r_cur, w_nxt_cur;
  logic               r_dir_dn, w_nxt_dir_dn;
  logic [RPT_W-1:0]   r_loop, w_nxt_loop;
  logic [DIV_W-1:0]   r_div, w_nxt_div;
  logic               r_cfg_err, w_nxt_cfg_err;
  logic [PRE_W-1:0]   r_pre, w_nxt_pre;
  logic [PIN_W-1:0]   r_first, w_nxt_first;
  logic [PIN_W-1:0]   r_last, w_nxt_last;
  logic [RPT_W-1:0]   r_rpt, w_nxt_rpt;
  logic               r_pp, w_nxt_pp;

  logic               w_abort;
  logic               w_cfg_ok;
  logic [DIV_W-1:0]   w_step_len;
  logic               w_step_end;
  logic               w_loop_end;
  logic [RPT_W-1:0]   w_loop_inc;
  logic               w_run_done;
  logic [NUM_PINS-1:0] w_onehot;

  assign w_abort    = stop | ~en;
  assign w_cfg_ok   = (prescaler != '0) && (first_pin <= last_pin) &&
                      ({1'b0, last_pin} < PIN_LIM);
  assign w_step_len = DIV_W'(r_pre) * DIV_W'(CLKS_PER_MS);
  assign w_step_end = (r_div == (w_step_len - DIV_W'(1)));
  assign w_loop_inc = (r_loop == '1) ? r_loop : r_loop + RPT_W'(1);
  assign w_run_done = (r_rpt != '0) &&
                      (({1'b0, r_loop} + (RPT_W+1)'(1)) == {1'b0, r_rpt});

  // Loop ends at the window's final position for the current mode and direction.
  always_comb begin
    w_loop_end = 1'b0;
    if (!r_pp) begin
      w_loop_end = (r_cur == r_last);
    end else if (!r_dir_dn) begin
      w_loop_end = (r_cur == r_last) && (r_first == r_last);
    end else begin
      w_loop_end = (r_cur == r_first);
    end
  end

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cur     = r_cur;
    w_nxt_dir_dn  = r_dir_dn;
    w_nxt_loop    = r_loop;
    w_nxt_div     = r_div;
    w_nxt_cfg_err = 1'b0;
    w_nxt_pre     = r_pre;
    w_nxt_first   = r_first;
    w_nxt_last    = r_last;
    w_nxt_rpt     = r_rpt;
    w_nxt_pp      = r_pp;
    if (w_abort) begin
      w_nxt_state = ST_IDLE;
      w_nxt_cur   = '0;
      w_nxt_div   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_nxt_cur = '0;
          if (start) begin
            if (w_cfg_ok) begin
              w_nxt_pre    = prescaler;
              w_nxt_first  = first_pin;
              w_nxt_last   = last_pin;
              w_nxt_rpt    = repeat_cnt;
              w_nxt_pp     = pingpong;
              w_nxt_cur    = first_pin;
              w_nxt_dir_dn = 1'b0;
              w_nxt_loop   = '0;
              w_nxt_div    = '0;
              w_nxt_state  = ST_RUN;
            end else begin
              w_nxt_cfg_err = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!w_step_end) begin
            w_nxt_div = r_div + DIV_W'(1);
          end else begin
            w_nxt_div = '0;
            if (w_loop_end) begin
              w_nxt_loop = w_loop_inc;
              if (w_run_done) begin
                w_nxt_state = ST_DONE;
                w_nxt_cur   = '0;
              end else begin
                w_nxt_cur    = r_first;
                w_nxt_dir_dn = 1'b0;
              end
            end else if (r_pp && !r_dir_dn && (r_cur == r_last)) begin
              w_nxt_dir_dn = 1'b1;
              w_nxt_cur    = r_cur - PIN_W'(1);
            end else if (r_dir_dn) begin
              w_nxt_cur = r_cur - PIN_W'(1);
            end else begin
              w_nxt_cur = r_cur + PIN_W'(1);
            end
          end
        end
        ST_DONE: begin
          w_nxt_state = ST_IDLE;
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_cur   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= ST_IDLE;
      r_cur     <= '0;
      r_dir_dn  <= 1'b0;
      r_loop    <= '0;
      r_div     <= '0;
      r_cfg_err <= 1'b0;
      r_pre     <= '0;
      r_first   <= '0;
      r_last    <= '0;
      r_rpt     <= '0;
      r_pp      <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cur     <= w_nxt_cur;
      r_dir_dn  <= w_nxt_dir_dn;
      r_loop    <= w_nxt_loop;
      r_div     <= w_nxt_div;
      r_cfg_err <= w_nxt_cfg_err;
      r_pre     <= w_nxt_pre;
      r_first   <= w_nxt_first;
      r_last    <= w_nxt_last;
      r_rpt     <= w_nxt_rpt;
      r_pp      <= w_nxt_pp;
    end
  end

  // Pin decode; the enable gates the bank immediately, ahead of the abort edge.
  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < NUM_PINS; i++) begin
      w_onehot[i] = (r_cur == PIN_W'(i));
    end
  end

  assign gpio_out   = (en && (r_state == ST_RUN)) ? w_onehot : '0;
  assign gpio_oeb   = en ? '0 : '1;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign cfg_err    = r_cfg_err;
  assign cur_pin    = r_cur;
  assign loop_count = r_loop;

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// Bench for gpio_seq_ctrl: expected pin sequences are built as queues from the
// window/mode/repeat rules and compared cycle by cycle.
module tb_gpio_seq_ctrl;

  localparam int NP  = 34;
  localparam int CPM = 4;

  logic          clk = 1'b0;
  logic          nrst, en, start, stop, pingpong;
  logic [13:0]   prescaler;
  logic [5:0]    first_pin, last_pin, cur_pin;
  logic [7:0]    repeat_cnt, loop_count;
  logic [NP-1:0] gpio_out, gpio_oeb;
  logic          busy, done, cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] ALL_ONES = (64'd1 << NP) - 64'd1;

  gpio_seq_ctrl #(.NUM_PINS(NP), .CLKS_PER_MS(CPM)) dut (
    .clk(clk), .nrst(nrst), .en(en), .start(start), .stop(stop),
    .prescaler(prescaler), .first_pin(first_pin), .last_pin(last_pin),
    .repeat_cnt(repeat_cnt), .pingpong(pingpong), .gpio_out(gpio_out),
    .gpio_oeb(gpio_oeb), .busy(busy), .done(done), .cfg_err(cfg_err),
    .cur_pin(cur_pin), .loop_count(loop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_cfg();
    prescaler  = 14'($urandom_range(0, 16383));
    first_pin  = 6'($urandom_range(0, 63));
    last_pin   = 6'($urandom_range(0, 63));
    repeat_cnt = 8'($urandom_range(0, 255));
    pingpong   = 1'($urandom_range(0, 1));
  endtask

  // Start a valid run and follow it to completion against the expected pin list.
  task automatic run_cfg(input int pre, input int fp, input int lp, input int rpt, input int pp);
    int q[$];
    int sl;
    for (int p = fp; p <= lp; p++) q.push_back(p);
    if (pp != 0 && fp != lp) for (int p = lp - 1; p >= fp; p--) q.push_back(p);
    sl = pre * CPM;
    prescaler = 14'(pre); first_pin = 6'(fp); last_pin = 6'(lp);
    repeat_cnt = 8'(rpt); pingpong = 1'(pp);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_loop_count", 64'(loop_count), 64'd0);
    for (int l = 0; l < rpt; l++) begin
      foreach (q[i]) begin
        for (int c = 0; c < sl; c++) begin
          chk("pin", 64'(gpio_out), 64'd1 << q[i]);
          chk("cur_pin", 64'(cur_pin), 64'(q[i]));
          chk("loop_count", 64'(loop_count), 64'(l));
          chk("busy_run", 64'(busy), 64'd1);
          chk("done_run", 64'(done), 64'd0);
          scramble_cfg();
          tick();
        end
      end
    end
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd1);
    chk("done_gpio", 64'(gpio_out), 64'd0);
    chk("done_loops", 64'(loop_count), 64'(rpt));
    tick();
    chk("post_done", 64'(done), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_loops", 64'(loop_count), 64'(rpt));
  endtask

  task automatic bad_cfg(input int pre, input int fp, input int lp);
    prescaler = 14'(pre); first_pin = 6'(fp); last_pin = 6'(lp);
    repeat_cnt = 8'd1; pingpong = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
    chk("cfg_err_busy", 64'(busy), 64'd0);
    chk("cfg_err_gpio", 64'(gpio_out), 64'd0);
    tick();
    chk("cfg_err_clear", 64'(cfg_err), 64'd0);
    chk("cfg_err_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    nrst = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0;
    prescaler = 14'd1; first_pin = '0; last_pin = '0; repeat_cnt = 8'd1; pingpong = 1'b0;
    #3;
    chk("rst_gpio", 64'(gpio_out), 64'd0);
    chk("rst_oeb", 64'(gpio_oeb), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_cur", 64'(cur_pin), 64'd0);
    chk("rst_loops", 64'(loop_count), 64'd0);
    #4 nrst = 1'b1;
    tick();

    run_cfg(1, 0, 33, 1, 0);
    run_cfg(2, 3, 5, 2, 1);

    bad_cfg(0, 2, 5);
    bad_cfg(1, 10, 5);
    bad_cfg(1, 3, 34);

    // stop beats start in IDLE
    prescaler = 14'd1; first_pin = 6'd1; last_pin = 6'd4; stop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("stop_start_busy", 64'(busy), 64'd0);
    chk("stop_start_err", 64'(cfg_err), 64'd0);

    // unbounded run on a single pin, loop_count saturates, then stop
    prescaler = 14'd1; first_pin = 6'd7; last_pin = 6'd7; repeat_cnt = 8'd0; pingpong = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      chk("hold_pin7", 64'(gpio_out), 64'd1 << 7);
      chk("hold_loops", 64'(loop_count), 64'(((k / 4) > 255) ? 255 : (k / 4)));
      chk("hold_done", 64'(done), 64'd0);
      scramble_cfg();
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_gpio", 64'(gpio_out), 64'd0);
    chk("stop_busy", 64'(busy), 64'd0);
    chk("stop_done", 64'(done), 64'd0);
    tick();
    chk("stop_no_done", 64'(done), 64'd0);

    // drop enable mid-run, then restart
    prescaler = 14'd1; first_pin = 6'd8; last_pin = 6'd12; repeat_cnt = 8'd3; pingpong = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    en = 1'b0;
    #1;
    chk("en_off_oeb", 64'(gpio_oeb), ALL_ONES);
    chk("en_off_gpio", 64'(gpio_out), 64'd0);
    tick();
    chk("en_off_busy", 64'(busy), 64'd0);
    chk("en_off_cur", 64'(cur_pin), 64'd0);
    en = 1'b1;
    #1;
    chk("en_on_oeb", 64'(gpio_oeb), 64'd0);
    tick();
    run_cfg(1, 8, 12, 2, 0);

    // randomized valid runs
    for (int r = 0; r < 6; r++) begin
      int fp, lp;
      fp = $urandom_range(0, 33);
      lp = $urandom_range(fp, (fp + 6 > 33) ? 33 : fp + 6);
      run_cfg($urandom_range(1, 2), fp, lp, $urandom_range(1, 3), $urandom_range(0, 1));
    end

    // asynchronous reset mid-step
    prescaler = 14'd2; first_pin = 6'd20; last_pin = 6'd25; repeat_cnt = 8'd4; pingpong = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();
    #2 nrst = 1'b0;
    #1;
    chk("arst_gpio", 64'(gpio_out), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_cur", 64'(cur_pin), 64'd0);
    chk("arst_loops", 64'(loop_count), 64'd0);
    #1 nrst = 1'b1;
    tick();
    run_cfg(1, 30, 33, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_seq_ctrl.md
# gpio_seq_ctrl

Programmable sequence controller that drives the 34-pin GPIO bank of the team project. It walks a one-hot "active pin" across a configured pin window (wrap or ping-pong), holds each pin for a prescaled number of milliseconds, repeats the window a configured number of times, then raises a one-cycle done interrupt. It sits between the Wishbone-programmed configuration registers and the GPIO outputs, and replaces free-running pin cycling with start/stop-controlled, bounded runs.

## Interface
- NUM_PINS, 34, width of GPIO bank
- CLKS_PER_MS, 10000, clock cycles per millisecond (10 MHz clock)
- clk  input  1  system clock
- nrst  input  1  asynchronous, active-low reset
- en  input  1  chip enable; low forces idle and tri-states GPIO
- start  input  1  request to begin a run (sampled in IDLE only)
- stop  input  1  abort; priority over start
- prescaler  input  14  ms per step; 0 is invalid
- first_pin  input  6  lowest pin of window
- last_pin  input  6  highest pin of window
- repeat_cnt  input  8  loops per run; 0 = run until stop
- pingpong  input  1  0 = wrap mode, 1 = ping-pong mode
- gpio_out  output  NUM_PINS  one-hot active pin, 0 when not running
- gpio_oeb  output  NUM_PINS  active-low output enable
- busy  output  1  high in RUN and DONE states
- done  output  1  one-cycle pulse on normal run completion (interrupt)
- cfg_err  output  1  one-cycle pulse when start rejected
- cur_pin  output  6  index of active pin
- loop_count  output  8  completed loops in current run

## Operation
- States: IDLE, RUN, DONE.
- Abort condition = stop | ~en. In any state, abort -> IDLE next edge, pin register cleared, divider cleared, no done pulse.
- IDLE: pin register 0. On start & ~abort: config valid iff prescaler != 0, first_pin <= last_pin, last_pin < NUM_PINS. Valid: latch prescaler/first/last/repeat/pingpong into shadow registers, cur_pin <= first_pin, direction <= up, loop_count <= 0, divider <= 0, -> RUN. Invalid: cfg_err = 1 for one cycle, stay IDLE.
- Input config changes while busy are ignored (shadow copies only).
- RUN: step_len = shadow_prescaler * CLKS_PER_MS, computed at 28 bits (max 163 830 000, no overflow). Divider counts 0..step_len-1; at step_len-1 it returns to 0 and the step advances.
- Wrap advance: cur != last -> cur+1; cur == last -> loop end.
- Ping-pong advance: up and cur != last -> cur+1; up and cur == last -> if first == last loop end, else direction down, cur-1; down and cur != first -> cur-1; down and cur == first -> loop end. Pin first is therefore held twice consecutively across a loop boundary (end of down sweep, start of next loop).
- Loop end: loop_count+1; if repeat != 0 and loop_count+1 == repeat -> DONE (pin register 0); else cur <= first, direction up, stay RUN.
- loop_count saturates at 255 when repeat = 0.
- DONE: done = 1, busy = 1, gpio_out = 0 for exactly one cycle, -> IDLE. start in DONE ignored.
- gpio_out = en ? one-hot(cur_pin) in RUN else 0; gpio_oeb = en ? all 0 : all 1 (combinational from en).

## Timing
- Reset values: state IDLE, gpio_out 0, busy 0, done 0, cfg_err 0, cur_pin 0, loop_count 0; gpio_oeb follows en.
- start sampled at edge N -> busy and one-hot(first_pin) visible after edge N, i.e. zero cycles idle between accept and first pin.
- Every step holds its pin exactly step_len cycles; consecutive pins switch on the same edge (no gap, no overlap).
- Last step ends at edge M: after M, gpio_out = 0, done = 1; after M+1, done = 0, busy = 0. New start accepted from edge M+2.
- stop and start both high in IDLE: stop wins, no run, no cfg_err.
- Reset asserted mid-run: all outputs to reset values immediately (asynchronous).

## Test plan
- CLKS_PER_MS=4, prescaler=1, first=0, last=33, repeat=1, wrap, pulse start -> pins 0..33 each high exactly 4 cycles in order, done one cycle after pin 33 drops, busy low next cycle, loop_count=1.
- CLKS_PER_MS=4, prescaler=2, first=3, last=5, repeat=2, pingpong -> pin order 3,4,5,4,3,3,4,5,4,3 each 8 cycles, then done pulse, loop_count=2.
- prescaler=0, or first=10 last=5, or last=34, with start -> cfg_err pulse only, busy stays 0, gpio_out stays 0.
- repeat=0, first=last=7, run 1000 cycles then assert stop -> pin 7 high continuously until stop, gpio_out 0 and busy 0 after the stop edge, no done pulse.
- Mid-run drop en -> gpio_oeb all 1, gpio_out 0, state IDLE; restore en with start -> run restarts at first_pin with loop_count 0.
- Change first_pin/prescaler during RUN -> sequence unchanged; assert nrst mid-step -> all outputs at reset values without a clock edge.
